// File: rtl/trap_controller_pkg.sv
// Shared types for the machine-mode trap controller: FSM states,
// interrupt cause codes, mip bit positions and the trap vector helper.
package trap_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_TRAP,
        ST_MRET,
        ST_REDIR
    } trap_state_t;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam int MIP_MEI = 11;
    localparam int MIP_MTI = 7;
    localparam int MIP_MSI = 3;

    // Interrupts jump to base+4*cause only in vectored mode;
    // exceptions always land on the base.
    function automatic logic [31:0] trap_target(
        input logic [31:0] tvec,
        input logic [31:0] cause,
        input logic        vec_en
    );
        logic [31:0] base;
        logic [31:0] tgt;
        base = {tvec[31:2], 2'b00};
        tgt  = base;
        if (vec_en && tvec[1:0] == 2'b01 && cause[31])
            tgt = base + {25'd0, cause[4:0], 2'b00};
        return tgt;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Pipeline/CSR side bundle of the trap controller.
// master: pipeline control + csr; slave: trap_controller.
interface trap_controller_if;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic [31:0] commit_pc;
    logic        pipe_idle;
    logic        csr_mie;
    logic [31:0] mie_bits;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mip_out;
    logic        flush;
    logic        csr_exception;
    logic [31:0] csr_exception_cause;
    logic [31:0] csr_exception_pc;
    logic        csr_mret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output irq_ext, irq_timer, irq_sw,
        output exc_valid, exc_cause, exc_pc,
        output mret_valid, commit_pc, pipe_idle,
        output csr_mie, mie_bits, mtvec, mepc,
        input  mip_out, flush,
        input  csr_exception, csr_exception_cause,
        input  csr_exception_pc, csr_mret,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  irq_ext, irq_timer, irq_sw,
        input  exc_valid, exc_cause, exc_pc,
        input  mret_valid, commit_pc, pipe_idle,
        input  csr_mie, mie_bits, mtvec, mepc,
        output mip_out, flush,
        output csr_exception, csr_exception_cause,
        output csr_exception_pc, csr_mret,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_controller_irq_sync.sv
// Synchroniser for one asynchronous level interrupt line.
// Ports: clk, nrst (async active-low), irq (async in), sync (out).
module trap_controller_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic irq,
    output logic sync
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            chain <= '0;
        else
            chain <= {chain[STAGES-2:0], irq};
    end

    assign sync = chain[STAGES-1];
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/exit sequencer: arbitrates, drains, strobes csr.
// Ports: clk, nrst (async active-low), bus (trap_controller_if.slave).
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input logic               clk,
    input logic               nrst,
    trap_controller_if.slave  bus
);
    logic        s_ext, s_tmr, s_sw;
    logic [31:0] mip;
    logic        irq_take;
    logic [31:0] irq_cause;

    trap_state_t state;
    logic        is_mret;
    logic [31:0] lat_cause, lat_epc;
    logic        flush_q, exc_q, mret_q, rv_q;
    logic [31:0] cause_q, pc_q, rpc_q;

    trap_controller_irq_sync #(.STAGES(SYNC_STAGES)) u_ext (
        .clk(clk), .nrst(nrst), .irq(bus.irq_ext), .sync(s_ext));
    trap_controller_irq_sync #(.STAGES(SYNC_STAGES)) u_tmr (
        .clk(clk), .nrst(nrst), .irq(bus.irq_timer), .sync(s_tmr));
    trap_controller_irq_sync #(.STAGES(SYNC_STAGES)) u_sw (
        .clk(clk), .nrst(nrst), .irq(bus.irq_sw), .sync(s_sw));

    always_comb begin
        mip          = '0;
        mip[MIP_MEI] = s_ext;
        mip[MIP_MTI] = s_tmr;
        mip[MIP_MSI] = s_sw;
    end

    assign irq_take = bus.csr_mie & |(mip & bus.mie_bits);

    // Highest-priority pending and enabled source.
    always_comb begin
        irq_cause = CAUSE_MTI;
        if (mip[MIP_MEI] & bus.mie_bits[MIP_MEI])
            irq_cause = CAUSE_MEI;
        else if (mip[MIP_MSI] & bus.mie_bits[MIP_MSI])
            irq_cause = CAUSE_MSI;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            is_mret   <= 1'b0;
            lat_cause <= '0;
            lat_epc   <= '0;
            flush_q   <= 1'b0;
            exc_q     <= 1'b0;
            mret_q    <= 1'b0;
            rv_q      <= 1'b0;
            cause_q   <= '0;
            pc_q      <= '0;
            rpc_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.exc_valid) begin
                        is_mret   <= 1'b0;
                        lat_cause <= bus.exc_cause;
                        lat_epc   <= bus.exc_pc;
                        flush_q   <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (bus.mret_valid) begin
                        is_mret   <= 1'b1;
                        lat_cause <= '0;
                        lat_epc   <= '0;
                        flush_q   <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (irq_take) begin
                        is_mret   <= 1'b0;
                        lat_cause <= irq_cause;
                        lat_epc   <= bus.commit_pc;
                        flush_q   <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.pipe_idle) begin
                        if (is_mret) begin
                            mret_q <= 1'b1;
                            state  <= ST_MRET;
                        end else begin
                            exc_q   <= 1'b1;
                            cause_q <= lat_cause;
                            pc_q    <= lat_epc;
                            state   <= ST_TRAP;
                        end
                    end
                end
                ST_TRAP, ST_MRET: begin
                    flush_q <= 1'b0;
                    exc_q   <= 1'b0;
                    mret_q  <= 1'b0;
                    cause_q <= '0;
                    pc_q    <= '0;
                    rv_q    <= 1'b1;
                    rpc_q   <= is_mret ? bus.mepc
                             : trap_target(bus.mtvec, lat_cause,
                                           VECTORED_EN);
                    state   <= ST_REDIR;
                end
                ST_REDIR: begin
                    rv_q  <= 1'b0;
                    rpc_q <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mip_out             = mip;
    assign bus.flush               = flush_q;
    assign bus.csr_exception       = exc_q;
    assign bus.csr_exception_cause = cause_q;
    assign bus.csr_exception_pc    = pc_q;
    assign bus.csr_mret            = mret_q;
    assign bus.redirect_valid      = rv_q;
    assign bus.redirect_pc         = rpc_q;
endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed table, random
// events against a transaction-level model, and a reset-abort sequence.
module tb_trap_controller;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    trap_controller_if bus ();

    trap_controller #(.SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .nrst(nrst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        exc, mret, ie, it, is, cmie;
        logic [31:0] cause, epc, cpc, mieb, tvec, mepc;
        int          drain;
        int          kind;   // 0 none, 1 trap, 2 mret
        logic [31:0] ecause, eepc, etgt;
    } vec_t;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_sw = 0;
        bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_pc = 0;
        bus.mret_valid = 0; bus.commit_pc = 0; bus.pipe_idle = 1;
        bus.csr_mie = 0; bus.mie_bits = 0; bus.mtvec = 0; bus.mepc = 0;
    endtask

    function automatic vec_t mk(
        logic exc, logic mret, logic ie, logic it, logic is, logic cmie,
        logic [31:0] cause, logic [31:0] epc, logic [31:0] cpc,
        logic [31:0] mieb, logic [31:0] tvec, logic [31:0] mepc,
        int drain, int kind, logic [31:0] ecause, logic [31:0] eepc,
        logic [31:0] etgt);
        vec_t v;
        v.exc = exc; v.mret = mret; v.ie = ie; v.it = it; v.is = is;
        v.cmie = cmie; v.cause = cause; v.epc = epc; v.cpc = cpc;
        v.mieb = mieb; v.tvec = tvec; v.mepc = mepc; v.drain = drain;
        v.kind = kind; v.ecause = ecause; v.eepc = eepc; v.etgt = etgt;
        return v;
    endfunction

    // Outcome from the priority rules and the vector arithmetic.
    function automatic vec_t model(vec_t v);
        vec_t r;
        logic [31:0] base;
        r = v;
        r.kind = 0; r.ecause = 0; r.eepc = 0; r.etgt = 0;
        if (v.exc) begin
            r.kind = 1; r.ecause = v.cause; r.eepc = v.epc;
        end else if (v.mret) begin
            r.kind = 2;
        end else if (v.cmie && v.ie && v.mieb[11]) begin
            r.kind = 1; r.ecause = 32'h8000_000B; r.eepc = v.cpc;
        end else if (v.cmie && v.is && v.mieb[3]) begin
            r.kind = 1; r.ecause = 32'h8000_0003; r.eepc = v.cpc;
        end else if (v.cmie && v.it && v.mieb[7]) begin
            r.kind = 1; r.ecause = 32'h8000_0007; r.eepc = v.cpc;
        end
        base = v.tvec - (v.tvec % 4);
        if (r.kind == 2)
            r.etgt = v.mepc;
        else if (r.kind == 1)
            r.etgt = (v.tvec % 4 == 1 && r.ecause >= 32'h8000_0000)
                   ? base + 4 * (r.ecause % 32) : base;
        return r;
    endfunction

    task automatic run(input string tag, input vec_t v);
        int n;
        logic [3:0] ectl;
        logic [31:0] emip;
        bus.irq_ext = v.ie; bus.irq_timer = v.it; bus.irq_sw = v.is;
        bus.csr_mie = 0; bus.mie_bits = v.mieb;
        bus.mtvec = v.tvec; bus.mepc = v.mepc;
        repeat (3) step();
        emip = (v.ie ? 32'h800 : 0) | (v.it ? 32'h80 : 0)
             | (v.is ? 32'h8 : 0);
        chk({tag, " mip"}, bus.mip_out, emip);
        bus.csr_mie = v.cmie;
        bus.exc_valid = v.exc; bus.exc_cause = v.cause;
        bus.exc_pc = v.epc; bus.mret_valid = v.mret;
        bus.commit_pc = v.cpc; bus.pipe_idle = 1;
        n = (v.kind == 0) ? 4 : 4 + v.drain;
        for (int i = 1; i <= n; i++) begin
            step();
            ectl[3] = v.kind != 0 && i <= 2 + v.drain;
            ectl[2] = v.kind == 1 && i == 2 + v.drain;
            ectl[1] = v.kind == 2 && i == 2 + v.drain;
            ectl[0] = v.kind != 0 && i == 3 + v.drain;
            chk($sformatf("%s s%0d ctl", tag, i),
                {28'd0, bus.flush, bus.csr_exception, bus.csr_mret,
                 bus.redirect_valid}, {28'd0, ectl});
            chk($sformatf("%s s%0d cause", tag, i),
                bus.csr_exception_cause, ectl[2] ? v.ecause : 32'd0);
            chk($sformatf("%s s%0d epc", tag, i),
                bus.csr_exception_pc, ectl[2] ? v.eepc : 32'd0);
            chk($sformatf("%s s%0d rpc", tag, i),
                bus.redirect_pc, ectl[0] ? v.etgt : 32'd0);
            // Inputs for the next cycle: drain stall, and a stray
            // event inside the sequence that must be ignored.
            bus.pipe_idle = (i > v.drain);
            bus.csr_mie = 0;
            bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_sw = 0;
            if (i == 1 && v.kind != 0) begin
                bus.exc_valid = 1; bus.mret_valid = 1;
                bus.exc_cause = 32'hE; bus.exc_pc = 32'hDEAD0;
                bus.commit_pc = 32'hBEEF0;
            end else begin
                bus.exc_valid = 0; bus.mret_valid = 0;
            end
        end
    endtask

    vec_t tbl[13];
    vec_t rv;

    initial begin
        idle_inputs();
        #3;
        chk("rst ctl", {28'd0, bus.flush, bus.csr_exception,
            bus.csr_mret, bus.redirect_valid}, 32'd0);
        chk("rst rpc", bus.redirect_pc, 32'd0);
        chk("rst mip", bus.mip_out, 32'd0);
        step();
        nrst = 1;
        step();

        tbl[0]  = mk(1,0,0,0,0,0, 2, 32'h100, 0, 0, 32'h1000, 0,
                     0, 1, 2, 32'h100, 32'h1000);
        tbl[1]  = mk(0,0,0,1,0,1, 0, 0, 32'h200, 32'h80, 32'h1001, 0,
                     0, 1, 32'h8000_0007, 32'h200, 32'h101C);
        tbl[2]  = mk(1,0,1,1,0,1, 5, 32'h300, 32'h204, 32'h888,
                     32'h1001, 0, 0, 1, 5, 32'h300, 32'h1000);
        tbl[3]  = mk(0,1,0,0,0,0, 0, 0, 0, 0, 0, 32'h2040,
                     4, 2, 0, 0, 32'h2040);
        tbl[4]  = mk(0,0,0,0,1,0, 0, 0, 32'h40, 32'h8, 32'h1000, 0,
                     0, 0, 0, 0, 0);
        tbl[5]  = mk(0,0,0,0,1,1, 0, 0, 32'h40, 32'h880, 32'h1000, 0,
                     0, 0, 0, 0, 0);
        tbl[6]  = mk(0,0,0,1,1,1, 0, 0, 32'h44, 32'h88, 32'h4001, 0,
                     2, 1, 32'h8000_0003, 32'h44, 32'h400C);
        tbl[7]  = mk(0,0,1,0,0,1, 0, 0, 32'h48, 32'h800, 32'h4000, 0,
                     0, 1, 32'h8000_000B, 32'h48, 32'h4000);
        tbl[8]  = mk(0,0,1,0,0,1, 0, 0, 32'h4C, 32'h800, 32'h4001, 0,
                     1, 1, 32'h8000_000B, 32'h4C, 32'h402C);
        tbl[9]  = mk(1,1,0,0,0,0, 7, 32'h500, 0, 0, 32'h6001, 32'h3000,
                     0, 1, 7, 32'h500, 32'h6000);
        tbl[10] = mk(0,1,1,0,0,1, 0, 0, 32'h50, 32'h800, 32'h6001,
                     32'h3000, 0, 2, 0, 0, 32'h3000);
        tbl[11] = mk(0,0,1,0,0,1, 0, 0, 32'h54, 32'h800, 32'h5003, 0,
                     0, 1, 32'h8000_000B, 32'h54, 32'h5000);
        tbl[12] = mk(0,0,0,1,1,1, 0, 0, 32'h58, 32'h888, 32'h7001, 0,
                     3, 1, 32'h8000_0003, 32'h58, 32'h700C);

        for (int k = 0; k < 13; k++)
            run($sformatf("vec%0d", k), tbl[k]);

        for (int k = 0; k < 40; k++) begin
            rv.exc  = ($urandom % 4) == 0;
            rv.mret = ($urandom % 4) == 0;
            rv.ie   = $urandom % 2;
            rv.it   = $urandom % 2;
            rv.is   = $urandom % 2;
            rv.cmie = ($urandom % 4) != 0;
            rv.cause = $urandom_range(0, 15);
            rv.epc  = $urandom & 32'hFFFF_FFFC;
            rv.cpc  = $urandom & 32'hFFFF_FFFC;
            rv.mieb = $urandom;
            rv.tvec = $urandom;
            rv.mepc = $urandom;
            rv.drain = $urandom_range(0, 3);
            rv = model(rv);
            run($sformatf("rnd%0d", k), rv);
        end

        // Reset while draining aborts the trap.
        idle_inputs();
        bus.mtvec = 32'h1000;
        bus.exc_valid = 1; bus.exc_cause = 2; bus.exc_pc = 32'h100;
        step();
        bus.exc_valid = 0; bus.pipe_idle = 0;
        step();
        chk("abort drain flush", {31'd0, bus.flush}, 32'd1);
        #2 nrst = 0;
        #1;
        chk("abort ctl", {28'd0, bus.flush, bus.csr_exception,
            bus.csr_mret, bus.redirect_valid}, 32'd0);
        chk("abort cause", bus.csr_exception_cause, 32'd0);
        step();
        nrst = 1; bus.pipe_idle = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("post abort %0d", i),
                {30'd0, bus.flush, bus.csr_exception}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
